// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the watch countdown timer: state encoding, MM:SS
// limits and the display-digit wrap helper.
package countdown_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSE  = 2'd2;
    localparam logic [1:0] ST_EXPIRE = 2'd3;

    localparam logic [5:0] MMSS_MAX  = 6'd59;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
    } mmss_t;

    // Minute/second field increment that rolls 59 back to 0 without carry.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value);
        return (value >= MMSS_MAX) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Divide-by-N pulse counter: every Nth accepted input pulse yields a
// one-clock registered output pulse; freezing (en low) also drops that pulse.
module tick_div #(
    parameter int unsigned N = 1000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic clr,
    input  logic en,
    input  logic in_tick,
    output logic out_tick
);

    localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en && in_tick) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: state registers are updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign out_tick = tick_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Timer-mode controller: cascades the 1 us tick to a 1 s tick and runs the
// IDLE/RUN/PAUSE/EXPIRE machine that counts the user-set MM:SS down to zero.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned USEC_PER_MSEC = 1000,
    parameter int unsigned MSEC_PER_SEC  = 1000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_usec,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] state,
    output logic       alarm
);

    logic [1:0] state_q, state_d;
    mmss_t      time_q,  time_d;
    logic       alarm_q, alarm_d;

    logic       div_clr;
    logic       div_en;
    logic       msec_tick;
    logic       sec_tick;
    logic       time_nonzero;
    logic       last_second;

    assign time_nonzero = (time_q.min != 6'd0) || (time_q.sec != 6'd0);
    assign last_second  = (time_q.min == 6'd0) && (time_q.sec == 6'd1);

    // Dividers only advance in RUN, so a pause freezes the partial second.
    assign div_en  = (state_q == ST_RUN);
    assign div_clr = btn_clear || ((state_q == ST_IDLE) && btn_start && time_nonzero);

    tick_div #(
        .N (USEC_PER_MSEC)
    ) u_msec_div (
        .clk      (clk),
        .reset_p  (reset_p),
        .clr      (div_clr),
        .en       (div_en),
        .in_tick  (tick_usec),
        .out_tick (msec_tick)
    );

    tick_div #(
        .N (MSEC_PER_SEC)
    ) u_sec_div (
        .clk      (clk),
        .reset_p  (reset_p),
        .clr      (div_clr),
        .en       (div_en),
        .in_tick  (msec_tick),
        .out_tick (sec_tick)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        alarm_d = alarm_q;

        if (btn_clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_start) begin
                        if (time_nonzero) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        if (btn_min_inc) begin
                            time_d.min = wrap_inc(time_q.min);
                        end
                        if (btn_sec_inc) begin
                            time_d.sec = wrap_inc(time_q.sec);
                        end
                    end
                end

                ST_RUN: begin
                    if (sec_tick) begin
                        if (time_q.sec != 6'd0) begin
                            time_d.sec = time_q.sec - 6'd1;
                        end else if (time_q.min != 6'd0) begin
                            time_d.min = time_q.min - 6'd1;
                            time_d.sec = MMSS_MAX;
                        end
                    end
                    // Reaching 00:00 outranks a simultaneous pause request.
                    if (sec_tick && last_second) begin
                        state_d = ST_EXPIRE;
                        alarm_d = 1'b1;
                    end else if (btn_start) begin
                        state_d = ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (btn_start) begin
                        state_d = ST_RUN;
                    end
                end

                ST_EXPIRE: begin
                    if (btn_start) begin
                        state_d = ST_IDLE;
                        alarm_d = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            alarm_q <= alarm_d;
        end
    end

    assign min   = time_q.min;
    assign sec   = time_q.sec;
    assign state = state_q;
    assign alarm = alarm_q;

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown-timer controller for the multi-purpose watch's timer mode. It takes the 1 µs tick pulse from the upstream prescaler and cascades it down to 1 ms and 1 s ticks internally. A run/pause/expire state machine starts, holds and clears that tick chain, and decrements a user-set MM:SS value. On reaching 00:00 it raises an alarm for the buzzer/LED logic.

## Interface
- USEC_PER_MSEC, default 1000: tick_usec pulses per msec tick.
- MSEC_PER_SEC, default 1000: msec ticks per sec tick.
- Both parameters are reduced only in simulation.
- clk  in  1  system clock.
- reset_p  in  1  asynchronous, active-high reset.
- tick_usec  in  1  one-clk-wide pulse, nominally every 1 µs.
- btn_start  in  1  one-clk pulse, debounced/edge-detected upstream; start/pause/resume/acknowledge.
- btn_clear  in  1  one-clk pulse; abort and zero.
- btn_min_inc  in  1  one-clk pulse; minute +1 (IDLE only).
- btn_sec_inc  in  1  one-clk pulse; second +1 (IDLE only).
- min  out  6  minutes, 0–59.
- sec  out  6  seconds, 0–59.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRE=3.
- alarm  out  1  high while in EXPIRE.

## Operation
- All outputs are registered.
- Reset values: min=0, sec=0, state=IDLE, alarm=0, both prescaler counts=0.
- Event priority within one cycle: btn_clear > btn_start > btn_min_inc/btn_sec_inc.
- The two inc buttons may coincide; both are applied.
- btn_clear in any state: go to IDLE, min=sec=0, alarm=0, prescalers cleared.
- IDLE:
  - btn_min_inc: min+1, wrapping 59→0.
  - btn_sec_inc: sec+1, wrapping 59→0, with no carry into min.
  - btn_start with min:sec ≠ 00:00: clear prescalers, go to RUN.
  - btn_start at 00:00: ignored.
- RUN:
  - Prescalers count tick_usec.
  - On each sec tick: if sec>0, sec−1; else if min>0, min−1 and sec=59.
  - The decrement that yields 00:00 also moves state to EXPIRE and sets alarm=1 in the same update.
  - btn_start: go to PAUSE.
  - Inc buttons ignored.
- PAUSE:
  - Prescaler counts frozen; tick_usec ignored.
  - btn_start: go to RUN, resuming the counts where they stopped, so the partial second is preserved.
  - Inc buttons ignored.
- EXPIRE:
  - alarm=1; min:sec holds 00:00.
  - btn_start or btn_clear: go to IDLE, alarm=0.
  - Inc buttons ignored.
- A sec tick and btn_start in the same RUN cycle: the decrement is applied and state goes to PAUSE.
  - Exception: if that decrement reaches 00:00, EXPIRE wins and the start press is dropped.

## Timing
- Each divider stage counts input pulses 0..N−1.
- On the Nth accepted pulse a stage clears its count and asserts its output tick, registered, for exactly one clk in the following cycle.
- Display update is visible the cycle after the sec tick.
- Pipeline from the 1,000,000th accepted tick_usec after start:
  - cycle +1: msec tick;
  - cycle +2: sec tick;
  - cycle +3: new min/sec/state/alarm.
- A tick_usec arriving in the same cycle as the IDLE→RUN btn_start is not counted.
- A tick_usec arriving in the same cycle as a PAUSE→RUN btn_start is not counted.
- An in-flight msec or sec pulse at the moment of pausing is discarded when the dividers are frozen; the dividers' output registers are also gated by enable.
- Reset asserted mid-run returns every register to its reset value immediately (asynchronous).

## Structure
- Shared package: the state encoding constants (IDLE/RUN/PAUSE/EXPIRE) and the 59 maximum for min/sec.
- Sub-module tick_div:
  - generic divide-by-N pulse counter;
  - inputs: clk, reset_p, clr, en, in_tick;
  - output: out_tick;
  - count width derived from N.
- tick_div is instantiated twice: usec→msec and msec→sec.
- The FSM and the MM:SS counter live in countdown_ctrl.

## Test plan
All scenarios use USEC_PER_MSEC=4, MSEC_PER_SEC=5 (20 tick_usec per second), with tick_usec pulsing every 3 clk.
1. Reset check → min=0, sec=0, state=0, alarm=0. btn_start at 00:00 → state stays 0.
2. Set 00:02, then start; the start cycle carries a tick_usec → sec=1 exactly 3 clk after the 20th counted tick. After 40 counted ticks → sec=0, state=3, alarm=1.
3. Set 01:00 and run one second → display 00:59. Separately, 59 sec_inc presses then 1 more → sec wraps to 0 with min unchanged.
4. Start 00:03, pause after 10 counted ticks, send 30 tick_usec while paused, resume → first decrement after 10 more counted ticks (not 20).
5. btn_clear and btn_start in the same cycle while in RUN → state=0, min:sec=00:00. Then btn_min_inc in RUN → ignored.
6. Reach EXPIRE, then btn_start → state=0, alarm=0. Repeat, pulsing reset_p while in RUN → all outputs zero within the reset cycle.
